// File: rtl/fetch_queue.sv
// Instruction fetch front-end: sequential PC generation, credit-limited imem requests,
// DEPTH-entry response FIFO, redirect flush and halt detection. Optional macro: FETCH_BYPASS_EN.
module fetch_queue #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'h0000_0073
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc,
    input  logic        dec_ready,
    output logic        halt
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned SW = CW + 1;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    entry_t        r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_occ;
    logic [CW-1:0] r_outst;
    logic [CW-1:0] r_drop_cnt;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_resp_pc;
    logic          r_fetch_stop;
    logic          r_halt;

    logic [PW-1:0] w_wptr_nxt;
    logic [PW-1:0] w_rptr_nxt;
    logic [CW-1:0] w_occ_nxt;
    logic [CW-1:0] w_outst_nxt;
    logic [CW-1:0] w_drop_nxt;
    logic [31:0]   w_fetch_pc_nxt;
    logic [31:0]   w_resp_pc_nxt;
    logic          w_fetch_stop_nxt;
    logic          w_halt_nxt;

    logic [SW-1:0] w_inflight;
    logic          w_credit;
    logic          w_req_fire;
    logic          w_rsp_acc;
    logic          w_rsp_keep;
    logic          w_bypass;
    logic          w_push;
    logic          w_pop;
    logic          w_consume;
    logic [31:0]   w_redirect_pc;
    entry_t        w_head;
    logic          w_unused;

    // Credit rule: FIFO entries plus in-flight requests never exceed DEPTH
    assign w_inflight    = SW'(r_occ) + SW'(r_outst);
    assign w_credit      = w_inflight < SW'(DEPTH);
    assign w_redirect_pc = {redirect_pc[31:2], 2'b00};
    assign w_unused      = ^redirect_pc[1:0];

    assign imem_req   = !rst && !r_fetch_stop && !redirect_valid && w_credit;
    assign imem_addr  = r_fetch_pc;
    assign w_req_fire = imem_req && imem_ready;

    // A response with nothing outstanding is a protocol error and is ignored
    assign w_rsp_acc  = imem_rvalid && (r_outst != '0);
    assign w_rsp_keep = w_rsp_acc && (r_drop_cnt == '0);

`ifdef FETCH_BYPASS_EN
    assign w_bypass = (r_occ == '0) && w_rsp_keep && !redirect_valid;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_head    = r_mem[r_rptr];
    assign dec_valid = ((r_occ != '0) || w_bypass) && !redirect_valid;
    assign dec_instr = w_bypass ? imem_rdata : w_head.instr;
    assign dec_pc    = w_bypass ? r_resp_pc  : w_head.pc;
    assign halt      = r_halt;

    assign w_consume = dec_valid && dec_ready;
    assign w_pop     = w_consume && !w_bypass;
    assign w_push    = w_rsp_keep && !redirect_valid && !(w_bypass && dec_ready);

    // Next-state for pointers, counters and status flags
    always_comb begin
        w_wptr_nxt       = r_wptr;
        w_rptr_nxt       = r_rptr;
        w_occ_nxt        = r_occ;
        w_outst_nxt      = r_outst - CW'(w_rsp_acc);
        w_drop_nxt       = r_drop_cnt;
        w_fetch_pc_nxt   = r_fetch_pc;
        w_resp_pc_nxt    = r_resp_pc;
        w_fetch_stop_nxt = r_fetch_stop;
        w_halt_nxt       = r_halt;

        if (redirect_valid) begin
            // outst already counts responses pending discard, so it alone covers everything in flight
            w_wptr_nxt       = '0;
            w_rptr_nxt       = '0;
            w_occ_nxt        = '0;
            w_drop_nxt       = r_outst - CW'(w_rsp_acc);
            w_fetch_pc_nxt   = w_redirect_pc;
            w_resp_pc_nxt    = w_redirect_pc;
            w_fetch_stop_nxt = 1'b0;
            w_halt_nxt       = 1'b0;
        end else begin
            w_outst_nxt = r_outst + CW'(w_req_fire) - CW'(w_rsp_acc);
            if (w_req_fire) begin
                w_fetch_pc_nxt = r_fetch_pc + 32'd4;
            end
            if (w_rsp_acc && (r_drop_cnt != '0)) begin
                w_drop_nxt = r_drop_cnt - CW'(1);
            end
            if (w_rsp_keep) begin
                w_resp_pc_nxt = r_resp_pc + 32'd4;
                if (imem_rdata == HALT_WORD) begin
                    w_fetch_stop_nxt = 1'b1;
                end
            end
            if (w_push) begin
                w_wptr_nxt = r_wptr + PW'(1);
            end
            if (w_pop) begin
                w_rptr_nxt = r_rptr + PW'(1);
            end
            w_occ_nxt = r_occ + CW'(w_push) - CW'(w_pop);
            if (w_consume && (dec_instr == HALT_WORD)) begin
                w_halt_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_occ        <= '0;
            r_outst      <= '0;
            r_drop_cnt   <= '0;
            r_fetch_pc   <= RESET_PC;
            r_resp_pc    <= RESET_PC;
            r_fetch_stop <= 1'b0;
            r_halt       <= 1'b0;
        end else begin
            r_wptr       <= w_wptr_nxt;
            r_rptr       <= w_rptr_nxt;
            r_occ        <= w_occ_nxt;
            r_outst      <= w_outst_nxt;
            r_drop_cnt   <= w_drop_nxt;
            r_fetch_pc   <= w_fetch_pc_nxt;
            r_resp_pc    <= w_resp_pc_nxt;
            r_fetch_stop <= w_fetch_stop_nxt;
            r_halt       <= w_halt_nxt;
        end
    end

    // Storage is cleared on reset so the idle head presents zeros to decode
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wptr] <= {imem_rdata, r_resp_pc};
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a variable-latency in-order imem model and a
// next-expected-PC tracker applied to every decode handshake.
module tb_fetch_queue;

    localparam logic [31:0] HALT_W = 32'h0000_0073;

`ifdef FETCH_BYPASS_EN
    localparam int          EXP_LAT = 1;
    localparam logic [31:0] S1_PC   = 32'h14;
    localparam logic [31:0] S2_ADDR = 32'h24;
    localparam logic [31:0] S2_HEAD = 32'h14;
    localparam logic [31:0] S6_PC   = 32'h1C;
`else
    localparam int          EXP_LAT = 2;
    localparam logic [31:0] S1_PC   = 32'h10;
    localparam logic [31:0] S2_ADDR = 32'h20;
    localparam logic [31:0] S2_HEAD = 32'h10;
    localparam logic [31:0] S6_PC   = 32'h18;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic        dec_ready;
    logic        halt;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(4), .RESET_PC(32'h0), .HALT_WORD(HALT_W)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .dec_valid(dec_valid), .dec_instr(dec_instr), .dec_pc(dec_pc),
        .dec_ready(dec_ready), .halt(halt)
    );

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          lat = 1;
    int          first_acc = -1;
    int          first_val = -1;
    int          n_wait;
    logic [31:0] halt_addr = 32'hFFFF_FFFF;
    logic [31:0] exp_pc = 32'h0;
    logic [31:0] q_addr[$];
    int          q_due[$];

    function automatic logic [31:0] word(input logic [31:0] a);
        return (a == halt_addr) ? HALT_W : (32'hC0DE_0000 | {16'h0, a[15:0]});
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; advances one clock and returns at the next negedge
    task automatic tick();
        #1;
        if (dec_valid && dec_ready) begin
            check("dec_pc", dec_pc, exp_pc);
            check("dec_instr", dec_instr, word(exp_pc));
            exp_pc += 32'd4;
        end
        if (dec_valid && first_val < 0) first_val = cyc;
        if (imem_req && imem_ready) begin
            if (first_acc < 0) first_acc = cyc;
            q_addr.push_back(imem_addr);
            q_due.push_back(cyc + lat);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            q_addr.delete();
            q_due.delete();
        end
        if (q_due.size() > 0 && q_due[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = word(q_addr[0]);
            void'(q_addr.pop_front());
            void'(q_due.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'hDEAD_BEEF;
        end
        @(negedge clk);
    endtask

    task automatic check_reset_outputs();
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_imem_addr", imem_addr, 32'h0);
        check("rst_dec_valid", 32'(dec_valid), 32'd0);
        check("rst_dec_instr", dec_instr, 32'h0);
        check("rst_dec_pc", dec_pc, 32'h0);
        check("rst_halt", 32'(halt), 32'd0);
    endtask

    initial begin
        rst = 1'b1; imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        redirect_valid = 1'b0; redirect_pc = 32'h0; dec_ready = 1'b0;
        @(negedge clk);
        tick(); tick();
        #1;
        check_reset_outputs();

        // Streaming with a 1-cycle imem and decode always ready
        rst = 1'b0; dec_ready = 1'b1; cyc = 0; exp_pc = 32'h0;
        #1;
        check("first_req", 32'(imem_req), 32'd1);
        check("first_addr", imem_addr, 32'h0);
        repeat (6) tick();
        check("first_latency", 32'(first_val - first_acc), 32'(EXP_LAT));
        check("stream_next_pc", exp_pc, S1_PC);

        // Decode stall: requests stop once the credit is used up
        dec_ready = 1'b0;
        repeat (12) tick();
        #1;
        check("stall_req", 32'(imem_req), 32'd0);
        check("stall_addr", imem_addr, S2_ADDR);
        check("stall_valid", 32'(dec_valid), 32'd1);
        check("stall_head_pc", dec_pc, S2_HEAD);
        dec_ready = 1'b1;
        repeat (12) tick();

        // Drain, then two requests in flight at 3-cycle latency before a redirect
        imem_ready = 1'b0;
        repeat (8) tick();
        #1;
        check("drain_valid", 32'(dec_valid), 32'd0);
        check("drain_addr", imem_addr, exp_pc);
        lat = 3; imem_ready = 1'b1;
        tick(); tick();
        imem_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h102; exp_pc = 32'h100;
        #1;
        check("redir_no_req", 32'(imem_req), 32'd0);
        check("redir_no_valid", 32'(dec_valid), 32'd0);
        tick();
        redirect_valid = 1'b0; imem_ready = 1'b1;
        #1;
        check("redir_req", 32'(imem_req), 32'd1);
        check("redir_addr", imem_addr, 32'h100);
        n_wait = 0;
        while (!dec_valid && n_wait < 12) begin tick(); n_wait++; end
        check("redir_dec_valid", 32'(dec_valid), 32'd1);
        check("redir_dec_pc", dec_pc, 32'h100);
        check("redir_dec_instr", dec_instr, word(32'h100));
        repeat (4) tick();

        // Halt word at PC 0x8
        imem_ready = 1'b0;
        repeat (10) tick();
        #1;
        check("drain2_valid", 32'(dec_valid), 32'd0);
        check("drain2_addr", imem_addr, exp_pc);
        lat = 1; halt_addr = 32'h8;
        redirect_valid = 1'b1; redirect_pc = 32'h0; exp_pc = 32'h0;
        tick();
        redirect_valid = 1'b0; imem_ready = 1'b1;
        n_wait = 0;
        while (!(dec_valid && dec_pc == 32'h8) && n_wait < 12) begin tick(); n_wait++; end
        check("halt_head_instr", dec_instr, HALT_W);
        check("halt_before_pop", 32'(halt), 32'd0);
        tick();
        #1;
        check("halt_after_pop", 32'(halt), 32'd1);
        repeat (6) tick();
        #1;
        check("halted_req", 32'(imem_req), 32'd0);
        check("halted_addr", imem_addr, 32'h10);
        check("halted_valid", 32'(dec_valid), 32'd0);
        check("halted_sticky", 32'(halt), 32'd1);

        // Halt fetched but not consumed, then redirected away
        halt_addr = 32'h4; dec_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h0; exp_pc = 32'h0;
        tick();
        redirect_valid = 1'b0;
        #1;
        check("halt_clr_redirect", 32'(halt), 32'd0);
        repeat (6) tick();
        #1;
        check("stop_unpopped_req", 32'(imem_req), 32'd0);
        check("stop_unpopped_addr", imem_addr, 32'hC);
        check("stop_unpopped_valid", 32'(dec_valid), 32'd1);
        check("stop_unpopped_pc", dec_pc, 32'h0);
        check("stop_unpopped_halt", 32'(halt), 32'd0);
        redirect_valid = 1'b1; redirect_pc = 32'h40; dec_ready = 1'b1; exp_pc = 32'h40;
        #1;
        check("redir40_valid", 32'(dec_valid), 32'd0);
        tick();
        redirect_valid = 1'b0; halt_addr = 32'hFFFF_FFFF;
        #1;
        check("redir40_halt", 32'(halt), 32'd0);
        check("redir40_req", 32'(imem_req), 32'd1);
        check("redir40_addr", imem_addr, 32'h40);
        repeat (6) tick();

        // Reset mid-stream with the FIFO partly full and a response in flight
        dec_ready = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        #1;
        check_reset_outputs();
        rst = 1'b0; dec_ready = 1'b1; exp_pc = 32'h0;
        #1;
        check("restart_req", 32'(imem_req), 32'd1);
        check("restart_addr", imem_addr, 32'h0);
        repeat (8) tick();
        check("restart_next_pc", exp_pc, S6_PC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
